// File: rtl/feat_accum_ctrl_pkg.sv
// Shared types and constants for the feature accumulation controller.
// Saturation limits are used only when FEAT_ACC_SAT_EN is defined.
package feat_accum_ctrl_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int FACCUM_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic longint sat_pos(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_neg(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/feat_accum_ctrl_if.sv
// Partial-sum input stream and drained-feature output stream.
interface feat_accum_ctrl_if
    import feat_accum_ctrl_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/feat_acc_add.sv
// Signed feature adder, one guard bit wide; clamps on overflow when
// FEAT_ACC_SAT_EN is defined, otherwise wraps in two's complement.
module feat_acc_add
    import feat_accum_ctrl_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [DWIDTH-1:0] sum,
    output logic                     sat
);

`ifdef FEAT_ACC_SAT_EN
    localparam logic signed [DWIDTH-1:0] POS_LIMIT = DWIDTH'(sat_pos(DWIDTH));
    localparam logic signed [DWIDTH-1:0] NEG_LIMIT = DWIDTH'(sat_neg(DWIDTH));

    logic signed [DWIDTH:0] wide;

    always_comb begin
        wide = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        sum  = wide[DWIDTH-1:0];
        sat  = 1'b0;
        // Guard bit disagreeing with the sign bit means the true sum left the range
        if (wide[DWIDTH] != wide[DWIDTH-1]) begin
            sat = 1'b1;
            sum = wide[DWIDTH] ? NEG_LIMIT : POS_LIMIT;
        end
    end
`else
    // Dropping the guard bit of the widened sum is exactly a wrapping add
    assign sum = a + b;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/feat_accum_ctrl.sv
// Multi-pass feature accumulator: sums pass_num passes of feat_size words
// into external SRAM, then drains the result. Saturation: FEAT_ACC_SAT_EN.
module feat_accum_ctrl
    import feat_accum_ctrl_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int FACCUM = FACCUM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FACCUM:0]   feat_size,
    input  logic [7:0]        pass_num,
    feat_accum_ctrl_if.slave  bus,
    output logic              done,
    output logic              sat_flag,
    output logic              mem_we1,
    output logic [FACCUM-1:0] mem_addr1,
    output logic [DWIDTH-1:0] write_data1,
    input  logic [DWIDTH-1:0] read_data1,
    input  logic [DWIDTH-1:0] read_data2,
    output logic [FACCUM-1:0] mem_addr2
);

    localparam logic [FACCUM-1:0] PTR_ONE  = 1;
    localparam logic [FACCUM:0]   SIZE_ONE = 1;

    state_t state_reg, state_next;

    logic [FACCUM:0]   size_reg;
    logic [7:0]        pass_total_reg;
    logic [FACCUM-1:0] word_reg;
    logic [7:0]        pass_reg;
    logic              acc_valid_reg;
    logic [FACCUM-1:0] acc_addr_reg;
    logic [DWIDTH-1:0] acc_data_reg;
    logic              acc_first_reg;
    logic              fwd_valid_reg;
    logic [DWIDTH-1:0] fwd_data_reg;
    logic [FACCUM-1:0] rd_ptr_reg;
    logic              out_valid_reg;
    logic              sat_reg;

    logic              accept;
    logic              out_hs;
    logic              start_ok;
    logic [FACCUM:0]   size_m1;
    logic              word_last;
    logic              pass_last;
    logic              drain_last;
    logic [DWIDTH-1:0] add_a;
    logic [DWIDTH-1:0] add_sum;
    logic              add_sat;

    assign size_m1    = size_reg - SIZE_ONE;
    assign word_last  = ({1'b0, word_reg} == size_m1);
    assign pass_last  = (pass_reg == pass_total_reg - 8'd1);
    assign drain_last = ({1'b0, rd_ptr_reg} == size_m1);
    assign start_ok   = start && (feat_size != '0) && (pass_num != '0);

    assign bus.in_ready  = (state_reg == ST_ACCUM);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = read_data1;
    assign bus.out_last  = out_valid_reg && drain_last;
    assign accept        = bus.in_valid && bus.in_ready;
    assign out_hs        = bus.out_valid && bus.out_ready;
    assign done          = out_hs && bus.out_last;
    assign sat_flag      = sat_reg;

    // Write lags acceptance by one cycle; drain look-ahead keeps one word per cycle
    assign mem_we1   = acc_valid_reg;
    assign mem_addr2 = word_reg;
    assign mem_addr1 = (state_reg == ST_DRAIN)
                     ? (out_hs ? rd_ptr_reg + PTR_ONE : rd_ptr_reg)
                     : acc_addr_reg;

    // A read issued while the same word was being written returns stale data,
    // so the value just written is forwarded in its place
    assign add_a = acc_first_reg ? '0
                 : (fwd_valid_reg ? fwd_data_reg : read_data2);

    feat_acc_add #(
        .DWIDTH (DWIDTH)
    ) u_add (
        .a   (add_a),
        .b   (acc_data_reg),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign write_data1 = add_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_ok) state_next = ST_ACCUM;
            ST_ACCUM: if (accept && word_last && pass_last) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_DRAIN;
            ST_DRAIN: if (done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_reg       <= '0;
            pass_total_reg <= '0;
            word_reg       <= '0;
            pass_reg       <= '0;
            acc_valid_reg  <= 1'b0;
            acc_addr_reg   <= '0;
            acc_data_reg   <= '0;
            acc_first_reg  <= 1'b0;
            fwd_valid_reg  <= 1'b0;
            fwd_data_reg   <= '0;
            rd_ptr_reg     <= '0;
            out_valid_reg  <= 1'b0;
            sat_reg        <= 1'b0;
        end else begin
            acc_valid_reg <= accept;
            fwd_valid_reg <= mem_we1 && accept && (mem_addr1 == mem_addr2);
            fwd_data_reg  <= write_data1;

            if (mem_we1 && add_sat) begin
                sat_reg <= 1'b1;
            end

            if (accept) begin
                acc_addr_reg  <= word_reg;
                acc_data_reg  <= bus.in_data;
                acc_first_reg <= (pass_reg == 8'd0);
                if (word_last) begin
                    word_reg <= '0;
                    pass_reg <= pass_reg + 8'd1;
                end else begin
                    word_reg <= word_reg + PTR_ONE;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    out_valid_reg <= 1'b0;
                    if (start_ok) begin
                        size_reg       <= feat_size;
                        pass_total_reg <= pass_num;
                        word_reg       <= '0;
                        pass_reg       <= '0;
                        sat_reg        <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    rd_ptr_reg    <= '0;
                    out_valid_reg <= 1'b0;
                end
                ST_DRAIN: begin
                    out_valid_reg <= !done;
                    if (out_hs) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    end
                end
                default: out_valid_reg <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_feat_accum_ctrl.sv
// Randomized scoreboard bench for feat_accum_ctrl with a behavioural SRAM and
// an arithmetic reference model of multi-pass accumulation.
module tb_feat_accum_ctrl;

    localparam int DW  = 16;
    localparam int FA  = 4;
    localparam int MAXW = 1 << FA;
    localparam int POS = (1 << (DW - 1)) - 1;
    localparam int NEG = -(1 << (DW - 1));
    localparam int MODV = 1 << DW;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [FA:0]   feat_size = '0;
    logic [7:0]    pass_num = '0;
    logic          done;
    logic          sat_flag;
    logic          mem_we1;
    logic [FA-1:0] mem_addr1;
    logic [DW-1:0] write_data1;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [FA-1:0] mem_addr2;

    feat_accum_ctrl_if #(.DWIDTH(DW)) bus ();

    feat_accum_ctrl #(
        .DWIDTH (DW),
        .FACCUM (FA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .feat_size   (feat_size),
        .pass_num    (pass_num),
        .bus         (bus),
        .done        (done),
        .sat_flag    (sat_flag),
        .mem_we1     (mem_we1),
        .mem_addr1   (mem_addr1),
        .write_data1 (write_data1),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .mem_addr2   (mem_addr2)
    );

    always #5 clk = ~clk;

    // SRAM: registered reads return the contents before a same-edge write
    logic [DW-1:0] mem [MAXW];
    always @(posedge clk) begin
        read_data1 <= mem[mem_addr1];
        read_data2 <= mem[mem_addr2];
        if (mem_we1) mem[mem_addr1] <= write_data1;
    end

    int   n_checks = 0;
    int   n_fail = 0;
    int   stim[$];
    exp_t exp_q[$];
    bit   exp_sat;
    int   rmode = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: per-word running sum over passes, clamped or wrapped each step
    function automatic void build_expected(input int size, input int passes);
        int acc[];
        int t;
        acc = new[size];
        exp_sat = 1'b0;
        for (int p = 0; p < passes; p++) begin
            for (int w = 0; w < size; w++) begin
                if (p == 0) begin
                    acc[w] = stim[w];
                end else begin
                    t = acc[w] + stim[p * size + w];
`ifdef FEAT_ACC_SAT_EN
                    if (t > POS) begin t = POS; exp_sat = 1'b1; end
                    if (t < NEG) begin t = NEG; exp_sat = 1'b1; end
`else
                    t = ((t % MODV) + MODV - NEG) % MODV + NEG;
`endif
                    acc[w] = t;
                end
            end
        end
        for (int w = 0; w < size; w++) begin
            exp_t e;
            e.data = acc[w];
            e.last = (w == size - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic fill_random(input int total, input int lo, input int hi);
        stim.delete();
        for (int i = 0; i < total; i++) stim.push_back(lo + int'($urandom_range(0, hi - lo)));
    endtask

    // Downstream ready: 0 = always, 1 = alternate starting high, 2 = random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each drain handshake, checks stall stability
    initial begin
        bit            stall_prev = 1'b0;
        logic [DW-1:0] prev_data = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", int'(bus.out_valid), 1);
                    check("hold_data", int'(bus.out_data), int'(prev_data));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", int'($signed(bus.out_data)), e.data);
                        check("out_last", int'(bus.out_last), int'(e.last));
                        check("done", int'(done), int'(e.last));
                    end
                end else begin
                    check("done_idle", int'(done), 0);
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic do_start(input int size, input int passes);
        start     = 1'b1;
        feat_size = (FA + 1)'(size);
        pass_num  = 8'(passes);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input int size, input int passes,
                       input bit gapless, input int mode);
        int  total;
        int  idx;
        int  cycles;
        bit  seen;
        total = size * passes;
        rmode = mode;
        build_expected(size, passes);
        do_start(size, passes);
        idx = 0;
        cycles = 0;
        while (idx < total && cycles < 20 * total + 50) begin
            bus.in_valid = gapless ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.in_data  = DW'(stim[idx]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            cycles++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check({tag, "_accepted"}, idx, total);
        if (gapless) check({tag, "_no_stall"}, cycles, total);
        seen = 1'b0;
        for (int c = 0; c < 8 * size + 40 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        @(posedge clk);
        #1;
        check({tag, "_sat_flag"}, int'(sat_flag), int'(exp_sat));
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle_ready"}, int'(bus.in_ready), 0);
        $display("run %s: size=%0d passes=%0d ready_mode=%0d", tag, size, passes, mode);
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #3;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_sat", int'(sat_flag), 0);
        check("rst_we", int'(mem_we1), 0);
        check("rst_addr1", int'(mem_addr1), 0);
        check("rst_addr2", int'(mem_addr2), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_start(0, 3);
        @(negedge clk);
        check("ignore_size0", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        do_start(4, 0);
        @(negedge clk);
        check("ignore_pass0", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;

        stim = '{1, 2, 3, 4};
        run("basic", 4, 1, 1'b1, 0);
        stim = '{10, -5, 7, 10, -5, 7, 10, -5, 7};
        run("three_pass", 3, 3, 1'b1, 0);
        stim = '{5, 5, 5, 5};
        run("single_word", 1, 4, 1'b1, 0);
        stim = '{30000, 30000};
        run("overflow", 1, 2, 1'b1, 0);
        stim = '{-30000, -30000, -30000};
        run("underflow", 1, 3, 1'b0, 2);
        stim = '{11, -22, 33, -44};
        run("toggle_ready", 4, 1, 1'b1, 1);
        fill_random(MAXW * 2, -2000, 2000);
        run("full_size", MAXW, 2, 1'b0, 2);

        // Abandon a run mid-accumulation, then confirm a clean restart
        do_start(4, 2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = DW'(100 + i);
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 0);
        check("midrst_we", int'(mem_we1), 0);
        check("midrst_addr1", int'(mem_addr1), 0);
        check("midrst_addr2", int'(mem_addr2), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        stim = '{7, 8, 9, 10, 1, 1, 1, 1};
        run("after_rst", 4, 2, 1'b1, 0);

        for (int r = 0; r < 8; r++) begin
            int sz;
            int np;
            sz = int'($urandom_range(1, MAXW));
            np = int'($urandom_range(1, 4));
            if (r % 3 == 2) fill_random(sz * np, -30000, 30000);
            else            fill_random(sz * np, -3000, 3000);
            run($sformatf("rand%0d", r), sz, np, 1'(r % 2), r % 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/feat_accum_ctrl.md
FEAT_ACCUM_CTRL -- requirements
Module: feat_accum_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, feature word width (signed).
REQ-002 SHALL have parameter FACCUM, default 10, feature SRAM address width (2**FACCUM words).
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have feat_size  input  FACCUM+1  words per pass, 1..2**FACCUM, sampled at start.
REQ-007 SHALL have pass_num  input  8  accumulation passes, 1..255, sampled at start.
REQ-008 SHALL have in_valid  input  1  partial-sum word valid.
REQ-009 SHALL have in_data  input  DWIDTH  signed partial-sum word.
REQ-010 SHALL have in_ready  output  1  partial-sum word accepted when in_valid and in_ready.
REQ-011 SHALL have out_valid  output  1  drained feature word valid.
REQ-012 SHALL have out_data  output  DWIDTH  drained feature word.
REQ-013 SHALL have out_last  output  1  qualifies final drained word.
REQ-014 SHALL have out_ready  input  1  downstream accepts word when out_valid and out_ready.
REQ-015 SHALL have done  output  1  one-cycle pulse on final drain handshake.
REQ-016 SHALL have sat_flag  output  1  sticky: an accumulation saturated in this run.
REQ-017 SHALL have mem_we1, mem_addr1 [FACCUM-1:0], write_data1 [DWIDTH-1:0]  output  SRAM port 1 write enable, address, write data.
REQ-018 SHALL have read_data1, read_data2  input  DWIDTH  SRAM read data, valid one cycle after address presented.
REQ-019 SHALL have mem_addr2  output  FACCUM  SRAM port 2 (read-only) address.

Function
REQ-020 SHALL implement states IDLE, ACCUM, FLUSH, DRAIN; start in IDLE with feat_size=0 or pass_num=0 SHALL be ignored.
REQ-021 IDLE->ACCUM on valid start; word counter and pass counter cleared; sat_flag cleared.
REQ-022 In ACCUM in_ready SHALL be 1; each accepted word at address w drives mem_addr2=w that cycle; w increments, wrapping to 0 at feat_size-1 and incrementing the pass counter.
REQ-023 One cycle after acceptance SHALL assert mem_we1 with mem_addr1=w and write_data1=in_data (pass 0) or read_data2+in_data (later passes), registered data.
REQ-024 Back-to-back writes/reads to same address (feat_size=1) SHALL read the value written at the preceding edge; no extra stall.
REQ-025 Last word of last pass accepted -> FLUSH for exactly one cycle (completes write), in_ready=0; FLUSH->DRAIN.
REQ-026 In DRAIN mem_we1=0; mem_addr1 = read pointer plus one if handshake this cycle, else read pointer; out_data=read_data1.
REQ-027 out_valid SHALL rise the cycle after DRAIN entry and stay high until final handshake; throughput one word per cycle with out_ready held high.
REQ-028 out_last=1 while pointer equals feat_size-1; its handshake pulses done and returns to IDLE.
REQ-029 Adder SHALL be DWIDTH+1 bits internally; result truncated or saturated per REQ-033/034.
REQ-030 in_ready=0 and out_valid=0 outside ACCUM and DRAIN respectively.

Reset
REQ-031 rst SHALL immediately force IDLE, counters 0, mem_we1=0, in_ready=0, out_valid=0, out_last=0, done=0, sat_flag=0, addresses 0.
REQ-032 rst mid-run SHALL abandon the run; SRAM contents are undefined afterwards.

Configuration
REQ-033 With FEAT_ACC_SAT_EN defined, overflow SHALL clamp to most positive/negative DWIDTH value and set sat_flag.
REQ-034 Without FEAT_ACC_SAT_EN, sum SHALL wrap (two's complement) and sat_flag SHALL be constant 0.

Structure
REQ-035 State encoding, DWIDTH/FACCUM defaults and saturation limits SHALL live in the shared parameters package.
REQ-036 Single sub-module feat_acc_add (combinational add with optional saturation); rest flat.

Verification
REQ-037 feat_size=4, pass_num=1, in 1,2,3,4 -> drain 1,2,3,4, out_last on 4th, done one pulse.
REQ-038 feat_size=3, pass_num=3, each pass 10,-5,7 -> drain 30,-15,21.
REQ-039 feat_size=1, pass_num=4, in 5 every cycle -> drain 20; no stall cycles in ACCUM.
REQ-040 DWIDTH=16, 2 passes of 30000 -> 32767 with sat_flag=1 (macro on); -5536, sat_flag=0 (macro off).
REQ-041 feat_size=4 drain with out_ready toggling 1,0,1,0 -> each word held stable while stalled, order preserved.
REQ-042 rst asserted mid-ACCUM -> all outputs reset same cycle; new start runs correctly.
